ifu_fetch_unit: RTL and testbench
=================================

Name: ifu_fetch_unit

Overview:
- Instruction fetch stage. Sits directly upstream of the decode stage.
- Issues one instruction-memory read per instruction and presents {instr, pc} to decode under a valid/ready handshake.
- Holds off the next fetch until writeback commits the current instruction and returns the next PC.
- Non-pipelined: at most one instruction in flight from fetch through writeback.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- CNT_WIDTH, 32, width of the fetched-instruction counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- wbu_valid  input  1  writeback commit pulse for the current instruction.
- dnpc  input  32  next PC from execute/writeback; sampled when wbu_valid is high in EXEC.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  32  read address; always equals pc.
- imem_resp_valid  input  1  read data valid.
- imem_rdata  input  32  read data.
- imem_resp_err  input  1  bus error, qualified by imem_resp_valid.
- ifu_valid  output  1  {instr, pc} valid to decode.
- idu_ready  input  1  decode accepts the instruction.
- instr  output  32  fetched instruction, registered.
- pc  output  32  address of instr, registered.
- fetch_fault  output  1  sticky fault flag.
- fetch_count  output  CNT_WIDTH  number of instructions handed to decode.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of current state or outstanding request:
  - state=REQ, pc=RESET_PC, instr=32'h0000_0013 (nop).
  - fetch_fault=0, fetch_count=0.
  - Outputs in the reset cycle and the first cycle after: ifu_valid=0. imem_req_valid=1 in the first cycle after reset.
- States: REQ, WAIT, HOLD, EXEC, FAULT. Outputs decode from state: imem_req_valid=(state==REQ), ifu_valid=(state==HOLD).
- REQ: imem_req_valid=1. On imem_req_valid && imem_req_ready -> WAIT. Otherwise stay; address stays stable.
- WAIT:
  - imem_resp_valid && !imem_resp_err -> instr<=imem_rdata, go to HOLD.
  - imem_resp_valid && imem_resp_err -> fetch_fault<=1, go to FAULT.
  - Otherwise stay.
- HOLD: ifu_valid=1 and instr/pc held stable. On idu_ready -> EXEC and fetch_count<=fetch_count+1 (wraps modulo 2^CNT_WIDTH).
- EXEC:
  - wbu_valid && dnpc[1:0]==0 -> pc<=dnpc, go to REQ.
  - wbu_valid && dnpc[1:0]!=0 -> pc<=dnpc, fetch_fault<=1, go to FAULT.
- FAULT: terminal. No requests, ifu_valid=0. Exit only via rst.
- Ignored inputs:
  - imem_resp_valid in any state other than WAIT.
  - wbu_valid in any state other than EXEC.
  - idu_ready in any state other than HOLD.
- Simultaneous events:
  - Request and response in the same cycle are not possible: the response is only sampled in WAIT.
  - Minimum latency: request accepted in cycle N, response in N+1, ifu_valid in N+2, decode accept in N+2, EXEC from N+3.
  - wbu_valid in cycle M gives imem_req_valid for dnpc in cycle M+1.
- Back-pressure: with idu_ready held low, HOLD persists indefinitely with instr/pc unchanged.
- Arithmetic: no PC increment inside the block. The next PC always comes from dnpc.

Test Plan:
- Reset, then imem_req_ready=1 and a 1-cycle response with rdata=32'h00100093, idu_ready=1 -> imem_addr=32'h8000_0000; ifu_valid rises 2 cycles after request acceptance with instr=32'h00100093, pc=32'h8000_0000; fetch_count=1.
- In EXEC, pulse wbu_valid with dnpc=32'h8000_0004 -> next cycle imem_req_valid=1 with imem_addr=32'h8000_0004; a stray wbu_valid in HOLD changes nothing.
- Hold idu_ready=0 for 5 cycles in HOLD -> ifu_valid stays 1 and instr/pc stay stable; fetch_count does not increment until idu_ready=1.
- imem_req_ready low for 3 cycles, then response delayed 4 cycles -> address stable throughout; exactly one accepted request; an unsolicited imem_resp_valid in REQ is ignored.
- Response with imem_resp_err=1 -> fetch_fault=1, state FAULT, no further requests. Separately, dnpc=32'h8000_0006 -> fetch_fault=1.
- Assert rst while in WAIT, then in HOLD -> next cycle pc=32'h8000_0000, ifu_valid=0, fetch_fault=0, fetch_count=0, and a new request issues.

Source files
------------

// File: rtl/ifu_fetch_unit.sv
// ifu_fetch_unit: non-pipelined instruction fetch, one instruction in flight
// until writeback returns the next pc.
module ifu_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wbu_valid,
   input  logic [31:0]          dnpc,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [31:0]          imem_addr,
   input  logic                 imem_resp_valid,
   input  logic [31:0]          imem_rdata,
   input  logic                 imem_resp_err,
   output logic                 ifu_valid,
   input  logic                 idu_ready,
   output logic [31:0]          instr,
   output logic [31:0]          pc,
   output logic                 fetch_fault,
   output logic [CNT_WIDTH-1:0] fetch_count
);
   typedef enum logic [2:0] {REQ, WAIT, HOLD, EXEC, FAULT} state_t;
   state_t state;
   assign imem_req_valid = state == REQ;
   // decode never sees a valid instruction while reset is being applied
   assign ifu_valid = state == HOLD && !rst;
   assign imem_addr = pc;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= REQ;
         pc <= RESET_PC;
         instr <= 32'h0000_0013;
         fetch_fault <= 1'b0;
         fetch_count <= '0;
      end else begin
         case (state)
            REQ: if (imem_req_ready) state <= WAIT;
            WAIT: if (imem_resp_valid) begin
               if (imem_resp_err) begin
                  fetch_fault <= 1'b1;
                  state <= FAULT;
               end else begin
                  instr <= imem_rdata;
                  state <= HOLD;
               end
            end
            HOLD: if (idu_ready) begin
               fetch_count <= fetch_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
               state <= EXEC;
            end
            EXEC: if (wbu_valid) begin
               pc <= dnpc;
               fetch_fault <= dnpc[1:0] != 2'b00;
               state <= dnpc[1:0] != 2'b00 ? FAULT : REQ;
            end
            default: state <= FAULT;
         endcase
      end
   end
endmodule

// File: tb/tb_ifu_fetch_unit.sv
// tb_ifu_fetch_unit: per-cycle directed vectors with hand-computed outputs,
// plus a latency sequence.
module tb_ifu_fetch_unit;
   logic clk = 0, rst = 1, wbu_valid = 0, imem_req_ready = 0, imem_resp_valid = 0;
   logic imem_resp_err = 0, idu_ready = 0;
   logic [31:0] dnpc = 0, imem_rdata = 0;
   logic imem_req_valid, ifu_valid, fetch_fault;
   logic [31:0] imem_addr, instr, pc, fetch_count;
   int checks = 0, errors = 0;

   ifu_fetch_unit dut (
      .clk(clk), .rst(rst), .wbu_valid(wbu_valid), .dnpc(dnpc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
      .imem_rdata(imem_rdata), .imem_resp_err(imem_resp_err),
      .ifu_valid(ifu_valid), .idu_ready(idu_ready), .instr(instr), .pc(pc),
      .fetch_fault(fetch_fault), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic r, rr, rsv, err, ir, wv;
      logic [31:0] rd, dn;
      logic erv, eiv, ef;
      logic [31:0] ei, ep, ec;
   } vec_t;
   vec_t v[$];

   localparam logic [31:0] R = 32'h8000_0000, NOP = 32'h13;
   localparam logic [31:0] I1 = 32'h00100093, I2 = 32'h00200113, I3 = 32'h00300193;
   localparam logic [31:0] I4 = 32'h00400213, I5 = 32'h00500293, I6 = 32'h00600313;

   task automatic add(input logic r, rr, rsv, err, ir, wv, input logic [31:0] rd, dn,
                      input logic erv, eiv, ef, input logic [31:0] ei, ep, ec);
      v.push_back('{r, rr, rsv, err, ir, wv, rd, dn, erv, eiv, ef, ei, ep, ec});
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      // r rr rsv err ir wv  rdata  dnpc  | erv eiv ef instr pc count
      add(0,1,0,0,0,0, 0, 0,                    1,0,0, NOP, R, 0);
      add(0,0,1,0,0,0, I1, 0,                   0,0,0, NOP, R, 0);
      add(0,0,0,0,1,1, 0, 32'h1234_5678,        0,1,0, I1, R, 0);
      add(0,0,0,0,0,0, 0, 0,                    0,0,0, I1, R, 1);
      add(0,0,0,0,0,1, 0, R+4,                  0,0,0, I1, R, 1);
      add(0,0,1,0,0,0, 32'hdead_beef, 0,        1,0,0, I1, R+4, 1);
      add(0,0,0,0,0,0, 0, 0,                    1,0,0, I1, R+4, 1);
      add(0,0,0,0,0,0, 0, 0,                    1,0,0, I1, R+4, 1);
      add(0,1,0,0,0,0, 0, 0,                    1,0,0, I1, R+4, 1);
      add(0,1,0,0,0,0, 0, 0,                    0,0,0, I1, R+4, 1);
      for (int i = 0; i < 3; i++) add(0,0,0,0,0,0, 0, 0, 0,0,0, I1, R+4, 1);
      add(0,0,1,0,0,0, I2, 0,                   0,0,0, I1, R+4, 1);
      for (int i = 0; i < 5; i++) add(0,0,0,0,0,0, 0, 0, 0,1,0, I2, R+4, 1);
      add(0,0,0,0,1,0, 0, 0,                    0,1,0, I2, R+4, 1);
      add(0,0,1,0,0,1, 32'hcafe_f00d, R+8,      0,0,0, I2, R+4, 2);
      add(0,1,0,0,0,0, 0, 0,                    1,0,0, I2, R+8, 2);
      add(0,0,1,1,0,0, 32'h1111_1111, 0,        0,0,0, I2, R+8, 2);
      add(0,1,1,0,1,1, 0, 0,                    0,0,1, I2, R+8, 2);
      add(0,1,1,0,1,1, 0, 0,                    0,0,1, I2, R+8, 2);
      add(1,0,0,0,0,0, 0, 0,                    0,0,1, I2, R+8, 2);
      add(0,1,0,0,0,0, 0, 0,                    1,0,0, NOP, R, 0);
      add(0,0,1,0,0,0, I3, 0,                   0,0,0, NOP, R, 0);
      add(0,0,0,0,1,0, 0, 0,                    0,1,0, I3, R, 0);
      add(0,0,0,0,0,1, 0, R+6,                  0,0,0, I3, R, 1);
      add(0,0,0,0,0,0, 0, 0,                    0,0,1, I3, R+6, 1);
      add(1,0,0,0,0,0, 0, 0,                    0,0,1, I3, R+6, 1);
      add(0,1,0,0,0,0, 0, 0,                    1,0,0, NOP, R, 0);
      add(1,0,0,0,0,0, 0, 0,                    0,0,0, NOP, R, 0);
      add(0,1,0,0,0,0, 0, 0,                    1,0,0, NOP, R, 0);
      add(0,0,1,0,0,0, I4, 0,                   0,0,0, NOP, R, 0);
      add(0,0,0,0,1,0, 0, 0,                    0,1,0, I4, R, 0);
      add(0,0,0,0,0,1, 0, R+16,                 0,0,0, I4, R, 1);
      add(0,1,0,0,0,0, 0, 0,                    1,0,0, I4, R+16, 1);
      add(0,0,1,0,0,0, I5, 0,                   0,0,0, I4, R+16, 1);
      add(1,0,0,0,0,0, 0, 0,                    0,0,0, I5, R+16, 1);
      add(0,0,0,0,0,0, 0, 0,                    1,0,0, NOP, R, 0);

      repeat (2) @(posedge clk);
      foreach (v[i]) begin
         @(negedge clk);
         rst = v[i].r; imem_req_ready = v[i].rr; imem_resp_valid = v[i].rsv;
         imem_resp_err = v[i].err; idu_ready = v[i].ir; wbu_valid = v[i].wv;
         imem_rdata = v[i].rd; dnpc = v[i].dn;
         #1;
         chk("imem_req_valid", i, {31'b0, imem_req_valid}, {31'b0, v[i].erv});
         chk("ifu_valid", i, {31'b0, ifu_valid}, {31'b0, v[i].eiv});
         chk("fetch_fault", i, {31'b0, fetch_fault}, {31'b0, v[i].ef});
         chk("instr", i, instr, v[i].ei);
         chk("pc", i, pc, v[i].ep);
         chk("imem_addr", i, imem_addr, v[i].ep);
         chk("fetch_count", i, fetch_count, v[i].ec);
      end

      // minimum latency: accept in N, response in N+1, ifu_valid in N+2
      begin
         int n;
         @(negedge clk);
         rst = 0; imem_req_ready = 1; imem_resp_valid = 0; imem_resp_err = 0;
         idu_ready = 0; wbu_valid = 0;
         n = 0;
         do begin
            @(negedge clk);
            n++;
            imem_req_ready = 0;
            imem_resp_valid = n == 1;
            imem_rdata = I6;
            #1;
         end while (!ifu_valid && n < 10);
         chk("latency", 100, n, 2);
         chk("lat_instr", 100, instr, I6);
         idu_ready = 1;
         @(negedge clk);
         idu_ready = 0;
         #1;
         chk("lat_count", 100, fetch_count, 1);
         chk("lat_ifu_valid", 100, {31'b0, ifu_valid}, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
